scoreboard_regfile: RTL and testbench

Parametrised successor to the pipeline's register file and dependency logic: a WIDTH-bit, 2^ADDRW-entry register file with two combinational read ports (s and d), one synchronous write-back port, hard-wired constant registers, optional write-through bypass, and a per-register pending-write scoreboard. It sits in the register-read stage. It issues busy flags in place of the hand-built address comparisons, so the stage can stall on true RAW hazards regardless of pipeline depth.

---
 rtl/scoreboard_regfile.sv | 109 ++++++++++
 tb/tb_scoreboard_regfile.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// Register file with constant low registers, optional write-back bypass and a
// per-register pending-write scoreboard for RAW hazard detection.
module scoreboard_regfile #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDRW   = 6,
  parameter int unsigned NCONST  = 4,
  parameter int unsigned MAXPEND = 3,
  parameter int unsigned BYPASS  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ADDRW-1:0] s_addr,
  input  logic [ADDRW-1:0] d_addr,
  output logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] d_data,
  output logic             s_busy,
  output logic             d_busy,
  input  logic             issue_en,
  input  logic [ADDRW-1:0] issue_addr,
  output logic             issue_ok,
  input  logic             wb_en,
  input  logic [ADDRW-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             sb_error
);

  localparam int unsigned NREGS = 1 << ADDRW;
  localparam int unsigned CNTW  = $clog2(MAXPEND + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXPEND);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [WIDTH-1:0] regs       [NREGS];
  logic [CNTW-1:0]  counts     [NREGS];
  logic [CNTW-1:0]  nextCounts [NREGS];
  logic             errSetC;

  function automatic logic isConst(input logic [ADDRW-1:0] a);
    return 32'(a) < NCONST;
  endfunction

  function automatic logic [WIDTH-1:0] constVal(input logic [ADDRW-1:0] a);
    case (32'(a))
      0:       return '0;
      1:       return WIDTH'(1);
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return '1;
    endcase
  endfunction

  // Returns {busy, data}; a same-cycle write-back retires one pending write.
  function automatic logic [WIDTH:0] readPort(input logic [ADDRW-1:0] a);
    if (isConst(a)) begin
      return {1'b0, constVal(a)};
    end
    if (BYPASS != 0 && wb_en && wb_addr == a) begin
      return {(counts[a] > CNT_ONE) || (counts[a] == CNT_ONE && issue_en && issue_addr == a),
              wb_data};
    end
    return {counts[a] != '0, regs[a]};
  endfunction

  always_comb {s_busy, s_data} = readPort(s_addr);
  always_comb {d_busy, d_data} = readPort(d_addr);

  assign issue_ok = isConst(issue_addr) || (counts[issue_addr] != CNT_MAX);

  // Register storage; constant slots are never written and read from constVal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_en && !isConst(wb_addr)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard next state: flush clears all, issue/write-back saturate at both ends.
  always_comb begin
    errSetC = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) begin
      nextCounts[i] = counts[i];
      if (flush) begin
        nextCounts[i] = '0;
      end else if (i >= int'(NCONST)) begin
        if (issue_en && issue_addr == ADDRW'(i) && !(wb_en && wb_addr == ADDRW'(i))) begin
          if (counts[i] == CNT_MAX) errSetC = 1'b1;
          else                      nextCounts[i] = counts[i] + CNT_ONE;
        end else if (wb_en && wb_addr == ADDRW'(i) && !(issue_en && issue_addr == ADDRW'(i))) begin
          if (counts[i] == '0) errSetC = 1'b1;
          else                 nextCounts[i] = counts[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) counts[i] <= '0;
    end else begin
      counts <= nextCounts;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       sb_error <= 1'b0;
    else if (errSetC) sb_error <= 1'b1;
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench: two instances (bypass on/off) compared each cycle
// against an array/counter model, plus directed literal checks.
module tb_scoreboard_regfile;

  localparam int MP = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  sAddr, dAddr, issueAddr, wbAddr;
  logic        issueEn, wbEn, flush;
  logic [15:0] wbData;
  logic [15:0] sData0, dData0, sData1, dData1;
  logic        sBusy0, dBusy0, sBusy1, dBusy1;
  logic        issueOk0, issueOk1, sbError0, sbError1;

  int          nTests = 0;
  int          nFail  = 0;
  bit          cmpOn  = 1'b0;

  int          mCnt  [64];
  logic [15:0] mRegs [64];
  bit          mErr;

  always #5 clock = ~clock;

  scoreboard_regfile #(.BYPASS(1)) dut0 (
    .clock(clock), .reset(reset), .s_addr(sAddr), .d_addr(dAddr),
    .s_data(sData0), .d_data(dData0), .s_busy(sBusy0), .d_busy(dBusy0),
    .issue_en(issueEn), .issue_addr(issueAddr), .issue_ok(issueOk0),
    .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData), .flush(flush),
    .sb_error(sbError0));

  scoreboard_regfile #(.BYPASS(0)) dut1 (
    .clock(clock), .reset(reset), .s_addr(sAddr), .d_addr(dAddr),
    .s_data(sData1), .d_data(dData1), .s_busy(sBusy1), .d_busy(dBusy1),
    .issue_en(issueEn), .issue_addr(issueAddr), .issue_ok(issueOk1),
    .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData), .flush(flush),
    .sb_error(sbError1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] constOf(input int a);
    case (a)
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] expData(input int a, input bit bp);
    if (a < 4) return constOf(a);
    if (bp && wbEn && int'(wbAddr) == a) return wbData;
    return mRegs[a];
  endfunction

  // With bypass, the write-back in flight retires one pending write this cycle.
  function automatic bit expBusy(input int a, input bit bp);
    int remaining;
    if (a < 4) return 1'b0;
    if (bp && wbEn && int'(wbAddr) == a) begin
      remaining = mCnt[a] - 1 + ((issueEn && int'(issueAddr) == a) ? 1 : 0);
      return remaining > 0;
    end
    return mCnt[a] > 0;
  endfunction

  function automatic bit expOk();
    return int'(issueAddr) < 4 || mCnt[issueAddr] < MP;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mCnt[i]  = 0;
      mRegs[i] = 16'h0000;
    end
    mErr = 1'b0;
  endtask

  task automatic modelEdge();
    int t, w;
    if (!reset) return;
    if (wbEn && int'(wbAddr) >= 4) mRegs[wbAddr] = wbData;
    if (flush) begin
      for (int i = 0; i < 64; i++) mCnt[i] = 0;
      return;
    end
    t = (issueEn && int'(issueAddr) >= 4) ? int'(issueAddr) : -1;
    w = (wbEn && int'(wbAddr) >= 4) ? int'(wbAddr) : -1;
    if (t >= 0 && t == w) return;
    if (t >= 0) begin
      if (mCnt[t] == MP) mErr = 1'b1;
      else mCnt[t]++;
    end
    if (w >= 0) begin
      if (mCnt[w] == 0) mErr = 1'b1;
      else mCnt[w]--;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    issueEn = 1'b0;
    wbEn    = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic asyncResetPulse();
    #2 reset = 1'b0;
    modelReset();
    #1;
    check("async_rst_err0", 32'(sbError0), 32'd0);
    check("async_rst_err1", 32'(sbError1), 32'd0);
    tick();
    reset = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (cmpOn) begin
      check("s_data_byp",   32'(sData0),   32'(expData(int'(sAddr), 1'b1)));
      check("d_data_byp",   32'(dData0),   32'(expData(int'(dAddr), 1'b1)));
      check("s_busy_byp",   32'(sBusy0),   32'(expBusy(int'(sAddr), 1'b1)));
      check("d_busy_byp",   32'(dBusy0),   32'(expBusy(int'(dAddr), 1'b1)));
      check("s_data_nobyp", 32'(sData1),   32'(expData(int'(sAddr), 1'b0)));
      check("d_data_nobyp", 32'(dData1),   32'(expData(int'(dAddr), 1'b0)));
      check("s_busy_nobyp", 32'(sBusy1),   32'(expBusy(int'(sAddr), 1'b0)));
      check("d_busy_nobyp", 32'(dBusy1),   32'(expBusy(int'(dAddr), 1'b0)));
      check("issue_ok0",    32'(issueOk0), 32'(expOk()));
      check("issue_ok1",    32'(issueOk1), 32'(expOk()));
      check("sb_error0",    32'(sbError0), 32'(mErr));
      check("sb_error1",    32'(sbError1), 32'(mErr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    sAddr = '0; dAddr = '0; issueAddr = '0; wbAddr = '0; wbData = '0;
    modelReset();
    #2;
    for (int a = 0; a < 64; a++) begin
      sAddr = 6'(a);
      dAddr = 6'(63 - a);
      #1;
      check("rst_s_data", 32'(sData0), 32'(constOf(a)));
      check("rst_d_data", 32'(dData1), 32'(constOf(63 - a)));
      check("rst_s_busy", 32'(sBusy0), 32'd0);
      check("rst_d_busy", 32'(dBusy1), 32'd0);
    end
    check("rst_issue_ok", 32'(issueOk0), 32'd1);
    check("rst_sb_error", 32'(sbError0), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cmpOn = 1'b1;

    // Writes and issues to a constant register have no effect.
    wbEn = 1'b1; wbAddr = 6'd3; wbData = 16'h1234;
    tick();
    idle(); issueEn = 1'b1; issueAddr = 6'd3;
    tick();
    idle(); sAddr = 6'd3; #1;
    check("const_r3_data", 32'(sData0), 32'hFFFF);
    check("const_r3_busy", 32'(sBusy0), 32'd0);
    check("const_no_err", 32'(sbError0), 32'd0);

    // RAW on r10: bypass vs no bypass.
    issueEn = 1'b1; issueAddr = 6'd10;
    tick();
    idle(); sAddr = 6'd10; #1;
    check("r10_busy_byp", 32'(sBusy0), 32'd1);
    check("r10_busy_nobyp", 32'(sBusy1), 32'd1);
    tick(); tick();
    wbEn = 1'b1; wbAddr = 6'd10; wbData = 16'hBEEF; #1;
    check("r10_wb_data_byp", 32'(sData0), 32'hBEEF);
    check("r10_wb_busy_byp", 32'(sBusy0), 32'd0);
    check("r10_wb_busy_nobyp", 32'(sBusy1), 32'd1);
    tick();
    idle(); #1;
    check("r10_data_nobyp", 32'(sData1), 32'hBEEF);
    check("r10_busy_after", 32'(sBusy1), 32'd0);

    // Saturation at MAXPEND on r7.
    issueEn = 1'b1; issueAddr = 6'd7;
    tick(); tick(); tick();
    issueEn = 1'b0; sAddr = 6'd7; #1;
    check("r7_issue_ok_full", 32'(issueOk0), 32'd0);
    check("r7_no_err_yet", 32'(sbError0), 32'd0);
    issueEn = 1'b1;
    tick();
    idle(); #1;
    check("r7_overissue_err", 32'(sbError0), 32'd1);
    wbEn = 1'b1; wbAddr = 6'd7; wbData = 16'h0007;
    tick(); tick();
    wbEn = 1'b0; #1;
    check("r7_busy_one_left", 32'(sBusy1), 32'd1);
    wbEn = 1'b1;
    tick();
    idle(); #1;
    check("r7_busy_clear", 32'(sBusy0), 32'd0);
    check("r7_issue_ok_back", 32'(issueOk0), 32'd1);

    // Flush with a concurrent write-back.
    issueEn = 1'b1; issueAddr = 6'd5; tick();
    issueAddr = 6'd6; tick();
    issueAddr = 6'd9; tick();
    idle(); flush = 1'b1; wbEn = 1'b1; wbAddr = 6'd5; wbData = 16'h00AA;
    tick();
    idle(); sAddr = 6'd5; dAddr = 6'd9; #1;
    check("flush_r5_data", 32'(sData1), 32'h00AA);
    check("flush_r5_busy", 32'(sBusy0), 32'd0);
    check("flush_r9_busy", 32'(dBusy0), 32'd0);

    asyncResetPulse();
    #1;
    check("rst_r5_cleared", 32'(sData0), 32'h0000);

    // Same-cycle issue and write-back on r12 leaves the count at 1.
    issueEn = 1'b1; issueAddr = 6'd12;
    tick();
    wbEn = 1'b1; wbAddr = 6'd12; wbData = 16'h1111; sAddr = 6'd12; #1;
    check("r12_both_busy_byp", 32'(sBusy0), 32'd1);
    check("r12_both_data_byp", 32'(sData0), 32'h1111);
    tick();
    idle(); #1;
    check("r12_still_busy", 32'(sBusy1), 32'd1);
    check("r12_data", 32'(sData1), 32'h1111);
    wbEn = 1'b1; wbAddr = 6'd20; wbData = 16'h2020;
    tick();
    idle(); #1;
    check("r20_underflow_err", 32'(sbError0), 32'd1);
    asyncResetPulse();

    // Randomised traffic over a small address window to force collisions.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sAddr = 6'($urandom_range(0, 15));
      dAddr = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) sAddr = 6'($urandom_range(0, 63));
      flush = ($urandom_range(0, 39) == 0);
      issueAddr = 6'($urandom_range(0, 15));
      issueEn = !flush && ($urandom_range(0, 9) < 4) &&
                (mCnt[issueAddr] < MP || $urandom_range(0, 19) == 0);
      wbAddr = 6'($urandom_range(0, 15));
      wbEn = !flush && ((mCnt[wbAddr] > 0) ? ($urandom_range(0, 9) < 6)
                                           : ($urandom_range(0, 29) == 0));
      wbData = 16'($urandom);
      if (cyc % 700 == 699) asyncResetPulse();
      else tick();
    end

    idle();
    tick();
    cmpOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
